// File: rtl/instr_sequencer.sv
// Two-byte fetch / decode sequencer that drives the register bank and owns the PC.
// Define SEQ_STEP_EN to add the step input and a STEP_WAIT gate before every EXEC.
module instr_sequencer #(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic [2:0] addr1,
  output logic [2:0] addr2,
  output logic [2:0] addrdest,
  output logic [2:0] control,
  output logic       enable,
  output logic [7:0] imm,
  output logic       halted
`ifdef SEQ_STEP_EN
  ,input  logic       step
`endif
);

  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_LDI  = 3'd5;
  localparam logic [2:0] OP_JMP  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

`ifdef SEQ_STEP_EN
  typedef enum logic [2:0] {
    FETCH_HI  = 3'd0,
    FETCH_LO  = 3'd1,
    EXEC      = 3'd2,
    HALT      = 3'd3,
    STEP_WAIT = 3'd4
  } state_e;
`else
  typedef enum logic [1:0] {
    FETCH_HI = 2'd0,
    FETCH_LO = 2'd1,
    EXEC     = 2'd2,
    HALT     = 2'd3
  } state_e;
`endif

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [2:0]  addr1_q, addr1_d, addr2_q, addr2_d;
  logic [2:0]  addrdest_q, addrdest_d, control_q, control_d;
  logic [7:0]  imm_q, imm_d;
  logic        enable_q, enable_d;
  logic        halted_q, halted_d;
  logic        fetch_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH_HI;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_HI: begin
        if (mem_ack) state_d = FETCH_LO;
        else         state_d = FETCH_HI;
      end
      FETCH_LO: begin
        if (mem_ack) begin
`ifdef SEQ_STEP_EN
          state_d = STEP_WAIT;
`else
          state_d = EXEC;
`endif
        end else begin
          state_d = FETCH_LO;
        end
      end
`ifdef SEQ_STEP_EN
      STEP_WAIT: begin
        if (step) state_d = EXEC;
        else      state_d = STEP_WAIT;
      end
`endif
      EXEC: begin
        if (ir_q[15:13] == OP_HALT) state_d = HALT;
        else                        state_d = FETCH_HI;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH_HI;
    endcase
  end

  // The request is masked during reset so it first rises once rst is released.
  assign fetch_s = (state_q == FETCH_HI) || (state_q == FETCH_LO);
  assign mem_req = fetch_s && !rst;

  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    addr1_d    = addr1_q;
    addr2_d    = addr2_q;
    addrdest_d = addrdest_q;
    control_d  = control_q;
    imm_d      = imm_q;
    enable_d   = 1'b0;
    if (fetch_s && mem_ack) begin
      pc_d = pc_q + 8'd1;
      if (state_q == FETCH_HI) ir_d[15:8] = mem_rdata;
      else                     ir_d[7:0]  = mem_rdata;
    end else if ((state_q == EXEC) && (ir_q[15:13] == OP_JMP)) begin
      pc_d = ir_q[7:0];
    end else begin
      pc_d = pc_q;
    end
    // Decode on the edge entering EXEC so fields and strobe are valid during EXEC.
    if (state_d == EXEC) begin
      case (ir_d[15:13])
        OP_ADD, OP_SUB, OP_AND, OP_NAND: begin
          control_d  = ir_d[15:13];
          addr1_d    = ir_d[9:7];
          addr2_d    = ir_d[6:4];
          addrdest_d = ir_d[12:10];
          enable_d   = 1'b1;
        end
        OP_LDI: begin
          control_d  = OP_LDI;
          addrdest_d = ir_d[12:10];
          imm_d      = ir_d[7:0];
          enable_d   = 1'b1;
        end
        default: enable_d = 1'b0;
      endcase
    end else begin
      enable_d = 1'b0;
    end
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= PC_RESET;
      ir_q       <= 16'h0000;
      addr1_q    <= 3'd0;
      addr2_q    <= 3'd0;
      addrdest_q <= 3'd0;
      control_q  <= 3'd0;
      imm_q      <= 8'h00;
      enable_q   <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      addr1_q    <= addr1_d;
      addr2_q    <= addr2_d;
      addrdest_q <= addrdest_d;
      control_q  <= control_d;
      imm_q      <= imm_d;
      enable_q   <= enable_d;
      halted_q   <= halted_d;
    end
  end

  assign mem_addr = pc_q;
  assign addr1    = addr1_q;
  assign addr2    = addr2_q;
  assign addrdest = addrdest_q;
  assign control  = control_q;
  assign imm      = imm_q;
  assign enable   = enable_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: instruction-level model checked every cycle, plus
// literal pins at hand-computed cycles. Covers the step gate when SEQ_STEP_EN is set.
module tb_instr_sequencer;

  logic       clk, rst, mem_req, mem_ack, enable, halted, step, ack_force;
  logic [7:0] mem_addr, mem_rdata, imm;
  logic [2:0] addr1, addr2, addrdest, control;
  logic [7:0] mem [256];
  int         wait_cycles;
  int         wcnt;
  int         checks;
  int         errors;
  int         en_cnt;

  logic [7:0] m_pc, m_hi, m_lo, m_imm;
  logic [2:0] m_a1, m_a2, m_dst, m_ctl;
  logic       m_en;
  int         m_phase;   // 0 fetch hi, 1 fetch lo, 2 wait step, 3 exec, 4 halted
  bit         m_valid;

  instr_sequencer dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .addr1(addr1), .addr2(addr2),
    .addrdest(addrdest), .control(control), .enable(enable), .imm(imm),
    .halted(halted)
`ifdef SEQ_STEP_EN
    , .step(step)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Program memory: acks after wait_cycles cycles of request, junk data otherwise.
  assign mem_ack   = ack_force | (mem_req && (wcnt == wait_cycles));
  assign mem_rdata = mem_ack ? mem[mem_addr] : 8'hA5;

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wcnt <= 0;
    else                     wcnt <= wcnt + 1;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic decode();
    int word, op;
    word = m_hi * 256 + m_lo;
    op   = word / 8192;
    if (op >= 1 && op <= 4) begin
      m_ctl = 3'(op);
      m_dst = 3'((word / 1024) % 8);
      m_a1  = 3'((word / 128) % 8);
      m_a2  = 3'((word / 16) % 8);
      m_en  = 1'b1;
    end else if (op == 5) begin
      m_ctl = 3'd5;
      m_dst = 3'((word / 1024) % 8);
      m_imm = m_lo;
      m_en  = 1'b1;
    end
  endtask

  // One clock: compare DUT against the model, then advance the model.
  task automatic cycle();
    int op;
    @(negedge clk);
    if (m_valid) begin
      chk("mem_req", {7'd0, mem_req}, {7'd0, (!rst && (m_phase == 0 || m_phase == 1))});
      chk("mem_addr", mem_addr, m_pc);
      chk("addr1", {5'd0, addr1}, {5'd0, m_a1});
      chk("addr2", {5'd0, addr2}, {5'd0, m_a2});
      chk("addrdest", {5'd0, addrdest}, {5'd0, m_dst});
      chk("control", {5'd0, control}, {5'd0, m_ctl});
      chk("enable", {7'd0, enable}, {7'd0, m_en});
      chk("imm", imm, m_imm);
      chk("halted", {7'd0, halted}, {7'd0, (m_phase == 4)});
    end
    if (rst) begin
      m_pc = 8'h00; m_hi = 8'h00; m_lo = 8'h00; m_imm = 8'h00;
      m_a1 = 3'd0; m_a2 = 3'd0; m_dst = 3'd0; m_ctl = 3'd0;
      m_en = 1'b0; m_phase = 0; m_valid = 1'b1;
    end else begin
      m_en = 1'b0;
      case (m_phase)
        0: if (mem_ack) begin
          m_hi = mem_rdata; m_pc = m_pc + 8'd1; m_phase = 1;
        end
        1: if (mem_ack) begin
          m_lo = mem_rdata; m_pc = m_pc + 8'd1;
`ifdef SEQ_STEP_EN
          m_phase = 2;
`else
          m_phase = 3;
          decode();
`endif
        end
        2: if (step) begin
          m_phase = 3;
          decode();
        end
        3: begin
          op = m_hi / 32;
          if (op == 7) m_phase = 4;
          else begin
            if (op == 6) m_pc = m_lo;
            m_phase = 0;
          end
        end
        default: m_phase = m_phase;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic load_prog_a();
    clear_mem();
    mem[0] = 8'h24; mem[1] = 8'hA0;        // ADD d1 s1 s2
    mem[2] = 8'hA8; mem[3] = 8'h5C;        // LDI d2 5C
    mem[4] = 8'hC0; mem[5] = 8'h40;        // JMP 40
    mem[8'h40] = 8'hE0; mem[8'h41] = 8'h00; // HALT
  endtask

  initial begin
    checks = 0; errors = 0; m_valid = 1'b0;
    rst = 1'b1; ack_force = 1'b0; wait_cycles = 0;
`ifdef SEQ_STEP_EN
    step = 1'b1;
`else
    step = 1'b0;
`endif

    // Zero-wait ADD, LDI, JMP, HALT
    load_prog_a();
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      #1;
`ifndef SEQ_STEP_EN
      case (c)
        1: begin chk("a_req1", {7'd0, mem_req}, 8'd1); chk("a_addr1", mem_addr, 8'h00);
                 chk("a_rst_ctl", {5'd0, control}, 8'd0); end
        2: chk("a_addr2", mem_addr, 8'h01);
        3: begin chk("add_en", {7'd0, enable}, 8'd1); chk("add_ctl", {5'd0, control}, 8'd1);
                 chk("add_a1", {5'd0, addr1}, 8'd1); chk("add_a2", {5'd0, addr2}, 8'd2);
                 chk("add_dst", {5'd0, addrdest}, 8'd1); chk("a_addr3", mem_addr, 8'h02); end
        6: begin chk("ldi_en", {7'd0, enable}, 8'd1); chk("ldi_ctl", {5'd0, control}, 8'd5);
                 chk("ldi_dst", {5'd0, addrdest}, 8'd2); chk("ldi_imm", imm, 8'h5C); end
        7: chk("ldi_en_drop", {7'd0, enable}, 8'd0);
        9: chk("jmp_en", {7'd0, enable}, 8'd0);
        10: begin chk("jmp_tgt", mem_addr, 8'h40); chk("jmp_req", {7'd0, mem_req}, 8'd1); end
        13, 16: begin chk("halt_flag", {7'd0, halted}, 8'd1); chk("halt_req", {7'd0, mem_req}, 8'd0); end
        default: ;
      endcase
`endif
      cycle();
    end

    // Two wait cycles per byte, wrap across 8'hFF, HALT with spurious acks
    clear_mem();
    mem[0] = 8'h00; mem[1] = 8'hE0; mem[2] = 8'hC0; mem[3] = 8'hFF;
    mem[8'hFF] = 8'h00;
    wait_cycles = 2;
    do_reset();
    for (int c = 1; c <= 35; c++) begin
      ack_force = (c >= 30 && c <= 33);
      #1;
`ifndef SEQ_STEP_EN
      case (c)
        1, 2, 3: begin chk("w_req", {7'd0, mem_req}, 8'd1); chk("w_addr", mem_addr, 8'h00); end
        4: chk("w_addr_lo", mem_addr, 8'h01);
        7: begin chk("w_exec_req", {7'd0, mem_req}, 8'd0); chk("w_exec_en", {7'd0, enable}, 8'd0); end
        15: chk("w_jmp_ff", mem_addr, 8'hFF);
        18: chk("w_wrap_lo", mem_addr, 8'h00);
        22: chk("w_wrap_pc", mem_addr, 8'h01);
        34: begin chk("w_halt", {7'd0, halted}, 8'd1); chk("w_spur_addr", mem_addr, 8'h03); end
        default: ;
      endcase
`endif
      cycle();
    end
    ack_force = 1'b0;

    // Reset in the middle of a fetch with one wait cycle
    load_prog_a();
    wait_cycles = 1;
    do_reset();
    for (int c = 1; c <= 14; c++) begin
      rst = (c == 8);
      #1;
`ifndef SEQ_STEP_EN
      case (c)
        5: chk("c_add_a1", {5'd0, addr1}, 8'd1);
        8: chk("c_rst_req", {7'd0, mem_req}, 8'd0);
        9: begin chk("c_pc0", mem_addr, 8'h00); chk("c_a1_0", {5'd0, addr1}, 8'd0);
                 chk("c_a2_0", {5'd0, addr2}, 8'd0); chk("c_dst_0", {5'd0, addrdest}, 8'd0);
                 chk("c_ctl_0", {5'd0, control}, 8'd0); chk("c_req_up", {7'd0, mem_req}, 8'd1); end
        default: ;
      endcase
`endif
      cycle();
    end
    rst = 1'b0;

`ifdef SEQ_STEP_EN
    // Step gate: nothing executes without a pulse, one pulse executes one instruction
    load_prog_a();
    wait_cycles = 0;
    step = 1'b0;
    do_reset();
    en_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      #1;
      en_cnt += int'(enable);
      if (c == 10) chk("s_wait_req", {7'd0, mem_req}, 8'd0);
      cycle();
    end
    chk("s_idle_en", 8'(en_cnt), 8'd0);
    en_cnt = 0;
    for (int c = 11; c <= 20; c++) begin
      step = (c == 11);
      #1;
      en_cnt += int'(enable);
      if (c == 12) chk("s_exec_ctl", {5'd0, control}, 8'd1);
      cycle();
    end
    chk("s_one_en", 8'(en_cnt), 8'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
